// File: rtl/pbs_pkg.sv
// Shared types and constants for the pbs battle datapath.
// Holds action encodings, FSM states and the default move table.
package pbs_pkg;

    typedef enum logic [1:0] {
        KIND_ATTACK = 2'b00,
        KIND_HEAL   = 2'b01,
        KIND_CATCH  = 2'b10,
        KIND_PASS   = 2'b11
    } act_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_TICK,
        ST_DONE,
        ST_OVER
    } state_e;

    typedef struct packed {
        logic [7:0] dmg;
        logic [7:0] acc;
        logic       poison;
    } move_t;

    localparam int unsigned DEFAULT_MOVES_N = 4;

    // Entry 0 sits in the least-significant slot.
    localparam move_t [DEFAULT_MOVES_N-1:0] DEFAULT_MOVES = {
        move_t'{dmg: 8'd1, acc: 8'd13, poison: 1'b1},
        move_t'{dmg: 8'd7, acc: 8'd7,  poison: 1'b0},
        move_t'{dmg: 8'd4, acc: 8'd12, poison: 1'b0},
        move_t'{dmg: 8'd2, acc: 8'd15, poison: 1'b0}
    };

endpackage

// File: rtl/pbs_battle_dp_p_move_table.sv
// Combinational move lookup: index -> damage, accuracy, poison flag.
// Indices beyond the default table wrap modulo its length.
module pbs_move_table
    import pbs_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 4,
    parameter int unsigned HP_W      = 4,
    parameter int unsigned ACC_W     = 4
) (
    input  logic [$clog2(NUM_MOVES)-1:0] move_i,
    output logic [HP_W-1:0]              dmg_o,
    output logic [ACC_W-1:0]             acc_o,
    output logic                         poison_o
);

    logic [1:0] idx;

    always_comb begin
        idx      = 2'(move_i);
        dmg_o    = HP_W'(DEFAULT_MOVES[idx].dmg);
        acc_o    = ACC_W'(DEFAULT_MOVES[idx].acc);
        poison_o = DEFAULT_MOVES[idx].poison;
    end

endmodule

// File: rtl/pbs_battle_dp_p.sv
// Battle datapath: HP, heals and poison for player and AI, resolving
// one attack/heal/catch/pass per valid/ready handshake.
module pbs_battle_dp_p
    import pbs_pkg::*;
#(
    parameter int unsigned HP_W         = 4,
    parameter int unsigned HP_MAX       = 15,
    parameter int unsigned HEAL_AMT     = 5,
    parameter int unsigned HEAL_CHARGES = 3,
    parameter int unsigned NUM_MOVES    = 4,
    parameter int unsigned ACC_W        = 4,
    parameter int unsigned POISON_DMG   = 1,
    parameter int unsigned POISON_TURNS = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                act_valid,
    output logic                                act_ready,
    input  logic                                act_side,
    input  logic [1:0]                          act_kind,
    input  logic [$clog2(NUM_MOVES)-1:0]        act_move,
    input  logic [ACC_W-1:0]                    rng_acc,
    input  logic [HP_W-1:0]                     rng_catch,
    output logic                                res_valid,
    output logic                                res_hit,
    output logic [HP_W-1:0]                     res_dmg,
    output logic [HP_W-1:0]                     p_hp,
    output logic [HP_W-1:0]                     ai_hp,
    output logic [$clog2(HEAL_CHARGES+1)-1:0]   p_heals,
    output logic [$clog2(HEAL_CHARGES+1)-1:0]   ai_heals,
    output logic [$clog2(POISON_TURNS+1)-1:0]   p_psn,
    output logic [$clog2(POISON_TURNS+1)-1:0]   ai_psn,
    output logic                                p_dead,
    output logic                                ai_dead,
    output logic                                caught,
    output logic                                game_over
);

    localparam int unsigned MW    = $clog2(NUM_MOVES);
    localparam int unsigned HW    = $clog2(HEAL_CHARGES + 1);
    localparam int unsigned PW    = $clog2(POISON_TURNS + 1);
    localparam int unsigned HPX_W = HP_W + 1;

    localparam logic [HP_W-1:0]  HP_FULL    = HP_W'(HP_MAX);
    localparam logic [HPX_W-1:0] HP_FULL_X  = HPX_W'(HP_MAX);
    localparam logic [HPX_W-1:0] HEAL_X     = HPX_W'(HEAL_AMT);
    localparam logic [HP_W-1:0]  PSN_DMG    = HP_W'(POISON_DMG);
    localparam logic [HW-1:0]    HEALS_FULL = HW'(HEAL_CHARGES);
    localparam logic [HW-1:0]    HEAL_ONE   = HW'(1);
    localparam logic [PW-1:0]    PSN_FULL   = PW'(POISON_TURNS);
    localparam logic [PW-1:0]    PSN_ONE    = PW'(1);

    state_e            state_q, state_d;
    logic              side_q, side_d;
    act_kind_e         kind_q, kind_d;
    logic [MW-1:0]     move_q, move_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [HP_W-1:0]   catch_q, catch_d;
    logic [HP_W-1:0]   p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
    logic [HW-1:0]     p_heals_q, p_heals_d, ai_heals_q, ai_heals_d;
    logic [PW-1:0]     p_psn_q, p_psn_d, ai_psn_q, ai_psn_d;
    logic              caught_q, caught_d;
    logic              res_valid_q, res_valid_d;
    logic              res_hit_q, res_hit_d;
    logic [HP_W-1:0]   res_dmg_q, res_dmg_d;

    logic              accept, do_resolve, do_tick, over;
    logic [HP_W-1:0]   mv_dmg;
    logic [ACC_W-1:0]  mv_acc;
    logic              mv_psn;
    logic [HP_W-1:0]   tgt_hp, actor_hp, removed, healed_hp;
    logic [HW-1:0]     actor_heals;
    logic [HPX_W-1:0]  heal_sum;

    pbs_move_table #(
        .NUM_MOVES (NUM_MOVES),
        .HP_W      (HP_W),
        .ACC_W     (ACC_W)
    ) u_move_table (
        .move_i   (move_q),
        .dmg_o    (mv_dmg),
        .acc_o    (mv_acc),
        .poison_o (mv_psn)
    );

    assign over = (p_hp_q == '0) || (ai_hp_q == '0) || caught_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A game-over raised at RESOLVE is seen in TICK, which skips the tick.
    always_comb begin
        state_d = state_q;
        if (over) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_IDLE:    if (act_valid) state_d = ST_RESOLVE;
                ST_RESOLVE: state_d = ST_TICK;
                ST_TICK:    state_d = ST_DONE;
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_OVER;
            endcase
        end
    end

    always_comb begin
        act_ready  = (state_q == ST_IDLE) && !over;
        accept     = act_valid && act_ready;
        do_resolve = (state_q == ST_RESOLVE);
        do_tick    = (state_q == ST_TICK) && !over;
    end

    always_comb begin
        tgt_hp      = side_q ? p_hp_q : ai_hp_q;
        actor_hp    = side_q ? ai_hp_q : p_hp_q;
        actor_heals = side_q ? ai_heals_q : p_heals_q;
        removed     = (tgt_hp < mv_dmg) ? tgt_hp : mv_dmg;
        heal_sum    = {1'b0, actor_hp} + HEAL_X;
        healed_hp   = (heal_sum > HP_FULL_X) ? HP_FULL : heal_sum[HP_W-1:0];
    end

    always_comb begin
        side_d      = side_q;
        kind_d      = kind_q;
        move_d      = move_q;
        acc_d       = acc_q;
        catch_d     = catch_q;
        p_hp_d      = p_hp_q;
        ai_hp_d     = ai_hp_q;
        p_heals_d   = p_heals_q;
        ai_heals_d  = ai_heals_q;
        p_psn_d     = p_psn_q;
        ai_psn_d    = ai_psn_q;
        caught_d    = caught_q;
        res_hit_d   = res_hit_q;
        res_dmg_d   = res_dmg_q;
        res_valid_d = do_tick;

        if (accept) begin
            side_d  = act_side;
            kind_d  = act_kind_e'(act_kind);
            move_d  = act_move;
            acc_d   = rng_acc;
            catch_d = rng_catch;
        end

        if (do_resolve) begin
            res_hit_d = 1'b0;
            res_dmg_d = '0;
            case (kind_q)
                KIND_ATTACK: begin
                    if (acc_q < mv_acc) begin
                        res_hit_d = 1'b1;
                        res_dmg_d = removed;
                        if (side_q) begin
                            p_hp_d = p_hp_q - removed;
                            if (mv_psn) p_psn_d = PSN_FULL;
                        end else begin
                            ai_hp_d = ai_hp_q - removed;
                            if (mv_psn) ai_psn_d = PSN_FULL;
                        end
                    end
                end
                KIND_HEAL: begin
                    if (actor_heals != '0) begin
                        res_hit_d = 1'b1;
                        if (side_q) begin
                            ai_hp_d    = healed_hp;
                            ai_heals_d = ai_heals_q - HEAL_ONE;
                        end else begin
                            p_hp_d    = healed_hp;
                            p_heals_d = p_heals_q - HEAL_ONE;
                        end
                    end
                end
                KIND_CATCH: begin
                    if (!side_q && (catch_q > ai_hp_q)) begin
                        res_hit_d = 1'b1;
                        caught_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (do_tick) begin
            if (p_psn_q != '0) begin
                p_hp_d  = (p_hp_q < PSN_DMG) ? '0 : p_hp_q - PSN_DMG;
                p_psn_d = p_psn_q - PSN_ONE;
            end
            if (ai_psn_q != '0) begin
                ai_hp_d  = (ai_hp_q < PSN_DMG) ? '0 : ai_hp_q - PSN_DMG;
                ai_psn_d = ai_psn_q - PSN_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_q      <= 1'b0;
            kind_q      <= KIND_PASS;
            move_q      <= '0;
            acc_q       <= '0;
            catch_q     <= '0;
            p_hp_q      <= HP_FULL;
            ai_hp_q     <= HP_FULL;
            p_heals_q   <= HEALS_FULL;
            ai_heals_q  <= HEALS_FULL;
            p_psn_q     <= '0;
            ai_psn_q    <= '0;
            caught_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_dmg_q   <= '0;
        end else begin
            side_q      <= side_d;
            kind_q      <= kind_d;
            move_q      <= move_d;
            acc_q       <= acc_d;
            catch_q     <= catch_d;
            p_hp_q      <= p_hp_d;
            ai_hp_q     <= ai_hp_d;
            p_heals_q   <= p_heals_d;
            ai_heals_q  <= ai_heals_d;
            p_psn_q     <= p_psn_d;
            ai_psn_q    <= ai_psn_d;
            caught_q    <= caught_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_dmg_q   <= res_dmg_d;
        end
    end

    always_comb begin
        res_valid = res_valid_q;
        res_hit   = res_hit_q;
        res_dmg   = res_dmg_q;
        p_hp      = p_hp_q;
        ai_hp     = ai_hp_q;
        p_heals   = p_heals_q;
        ai_heals  = ai_heals_q;
        p_psn     = p_psn_q;
        ai_psn    = ai_psn_q;
        p_dead    = (p_hp_q == '0);
        ai_dead   = (ai_hp_q == '0);
        caught    = caught_q;
        game_over = over;
    end

endmodule

// File: tb/tb_pbs_battle_dp_p.sv
// Randomized scoreboard bench for pbs_battle_dp_p against a rule-level model.
// Results are queued at issue time and popped by a monitor on res_valid.
module tb_pbs_battle_dp_p;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       act_valid = 1'b0;
    logic       act_ready;
    logic       act_side = 1'b0;
    logic [1:0] act_kind = 2'b11;
    logic [1:0] act_move = '0;
    logic [3:0] rng_acc = '0;
    logic [3:0] rng_catch = '0;
    logic       res_valid, res_hit;
    logic [3:0] res_dmg, p_hp, ai_hp;
    logic [1:0] p_heals, ai_heals, p_psn, ai_psn;
    logic       p_dead, ai_dead, caught, game_over;

    always #5 clk = ~clk;

    pbs_battle_dp_p #(
        .HP_W(4), .HP_MAX(15), .HEAL_AMT(5), .HEAL_CHARGES(3),
        .NUM_MOVES(4), .ACC_W(4), .POISON_DMG(1), .POISON_TURNS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .act_valid(act_valid), .act_ready(act_ready),
        .act_side(act_side), .act_kind(act_kind), .act_move(act_move),
        .rng_acc(rng_acc), .rng_catch(rng_catch),
        .res_valid(res_valid), .res_hit(res_hit), .res_dmg(res_dmg),
        .p_hp(p_hp), .ai_hp(ai_hp), .p_heals(p_heals), .ai_heals(ai_heals),
        .p_psn(p_psn), .ai_psn(ai_psn), .p_dead(p_dead), .ai_dead(ai_dead),
        .caught(caught), .game_over(game_over)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int hit; int dmg; int php; int aihp; int ppsn; int aipsn; int unsigned at;
    } exp_t;
    exp_t sb[$];

    // Reference model: index 0 = player, 1 = AI.
    int MDMG[4] = '{2, 4, 7, 1};
    int MACC[4] = '{15, 12, 7, 13};
    int MPSN[4] = '{0, 0, 0, 1};
    int m_hp[2], m_heals[2], m_psn[2];
    int m_caught, m_hit, m_dmg;

    function automatic int m_over();
        return (m_hp[0] == 0 || m_hp[1] == 0 || m_caught != 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_res_valid: got pulse, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_latency", int'(cyc), int'(e.at));
                check("res_hit", int'(res_hit), e.hit);
                check("res_dmg", int'(res_dmg), e.dmg);
                check("res_p_hp", int'(p_hp), e.php);
                check("res_ai_hp", int'(ai_hp), e.aihp);
                check("res_p_psn", int'(p_psn), e.ppsn);
                check("res_ai_psn", int'(ai_psn), e.aipsn);
            end
        end
    end

    task automatic check_state();
        check("p_hp", int'(p_hp), m_hp[0]);
        check("ai_hp", int'(ai_hp), m_hp[1]);
        check("p_heals", int'(p_heals), m_heals[0]);
        check("ai_heals", int'(ai_heals), m_heals[1]);
        check("p_psn", int'(p_psn), m_psn[0]);
        check("ai_psn", int'(ai_psn), m_psn[1]);
        check("p_dead", int'(p_dead), (m_hp[0] == 0) ? 1 : 0);
        check("ai_dead", int'(ai_dead), (m_hp[1] == 0) ? 1 : 0);
        check("caught", int'(caught), m_caught);
        check("game_over", int'(game_over), m_over());
        check("act_ready", int'(act_ready), 1 - m_over());
        check("held_res_hit", int'(res_hit), m_hit);
        check("held_res_dmg", int'(res_dmg), m_dmg);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_hp[s] = 15; m_heals[s] = 3; m_psn[s] = 0;
        end
        m_caught = 0; m_hit = 0; m_dmg = 0;
    endtask

    task automatic reset_dut();
        check("pending_results", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        act_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_state();
    endtask

    task automatic do_action(input int side, input int kind, input int mv,
                             input int acc, input int cat);
        int n;
        int tgt;
        int unsigned acc_cyc;
        exp_t e;
        n = 0;
        while (!act_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!act_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got act_ready=0, expected 1 within 20 cycles");
            return;
        end
        act_side  = side[0];
        act_kind  = kind[1:0];
        act_move  = mv[1:0];
        rng_acc   = acc[3:0];
        rng_catch = cat[3:0];
        act_valid = 1'b1;
        @(posedge clk);
        #1;
        act_valid = 1'b0;
        acc_cyc = cyc;

        m_hit = 0;
        m_dmg = 0;
        case (kind)
            0: begin
                tgt = (side != 0) ? 0 : 1;
                if (acc < MACC[mv]) begin
                    m_hit = 1;
                    m_dmg = (m_hp[tgt] < MDMG[mv]) ? m_hp[tgt] : MDMG[mv];
                    m_hp[tgt] -= m_dmg;
                    if (MPSN[mv] != 0) m_psn[tgt] = 3;
                end
            end
            1: if (m_heals[side] > 0) begin
                m_hit = 1;
                m_hp[side] = (m_hp[side] + 5 > 15) ? 15 : m_hp[side] + 5;
                m_heals[side]--;
            end
            2: if (side == 0 && cat > m_hp[1]) begin
                m_hit = 1;
                m_caught = 1;
            end
            default: ;
        endcase
        if (m_over() == 0) begin
            for (int s = 0; s < 2; s++) begin
                if (m_psn[s] > 0) begin
                    m_hp[s] = (m_hp[s] > 0) ? m_hp[s] - 1 : 0;
                    m_psn[s]--;
                end
            end
            e.hit = m_hit; e.dmg = m_dmg; e.php = m_hp[0]; e.aihp = m_hp[1];
            e.ppsn = m_psn[0]; e.aipsn = m_psn[1]; e.at = acc_cyc + 2;
            sb.push_back(e);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic poke_while_over();
        act_side = 1'b0; act_kind = 2'b00; act_move = 2'd2; rng_acc = '0;
        act_valid = 1'b1;
        repeat (5) @(negedge clk);
        act_valid = 1'b0;
        check_state();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_dut();

        do_action(0, 0, 0, 3, 0);
        check("plan_first_hit_ai_hp", int'(ai_hp), 13);
        do_action(0, 0, 2, 7, 0);
        do_action(0, 0, 2, 6, 0);
        do_action(1, 0, 3, 0, 0);
        check("plan_poison_p_hp", int'(p_hp), 13);
        do_action(0, 3, 0, 0, 0);
        do_action(1, 3, 0, 0, 0);
        check("plan_poison_end_p_hp", int'(p_hp), 11);
        for (int i = 0; i < 4; i++) do_action(0, 1, 0, 0, 0);
        do_action(0, 0, 0, 0, 0);
        do_action(1, 2, 0, 0, 15);
        do_action(0, 2, 0, 0, int'(ai_hp));
        do_action(0, 2, 0, 0, int'(ai_hp) + 1);
        check("plan_caught", int'(caught), 1);
        poke_while_over();

        reset_dut();
        do_action(0, 0, 2, 0, 0);
        do_action(0, 0, 1, 0, 0);
        do_action(0, 0, 0, 0, 0);
        do_action(0, 0, 2, 0, 0);
        check("plan_sat_res_dmg", int'(res_dmg), 2);
        poke_while_over();

        reset_dut();
        do_action(1, 0, 1, 0, 0);
        @(negedge clk);
        act_side = 1'b0; act_kind = 2'b00; act_move = 2'd1; rng_acc = '0;
        act_valid = 1'b1;
        @(posedge clk);
        #1;
        act_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_p_hp", int'(p_hp), 15);
        check("midreset_ai_hp", int'(ai_hp), 15);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_state();

        for (int g = 0; g < 25; g++) begin
            reset_dut();
            for (int a = 0; a < 40 && m_over() == 0; a++) begin
                do_action(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)));
            end
            if (m_over() != 0) poke_while_over();
        end

        repeat (4) @(negedge clk);
        check("pending_results", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
